// File: rtl/execute_mem_dcache_refill_if.sv
// Bundle of the miss, memory-burst and cache write-port signals of the
// dcache refill controller. The controller uses the master view; the
// memory stage, memory bus and cache arrays see the slave view.
interface execute_mem_dcache_refill_if;
    // Miss request from the memory stage
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        inv_all;
    logic        busy;

    // Forwarding of the requested word to the stalled load
    logic        refill_done;
    logic        fwd_valid;
    logic [31:0] fwd_data;

    // Burst read channel towards memory
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic        rlast_err;

    // Data RAM write port
    logic        data_we;
    logic [10:0] data_addr;
    logic [31:0] data_din;

    // Tag array write port
    logic        tag_we;
    logic [7:0]  tag_addr;
    logic        tag_valid;
    logic [18:0] tag_din;

    modport master (
        input  miss_valid, miss_addr, inv_all,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        output miss_ready, busy, refill_done, fwd_valid, fwd_data,
        output mem_arvalid, mem_araddr, mem_arlen, mem_rready, rlast_err,
        output data_we, data_addr, data_din,
        output tag_we, tag_addr, tag_valid, tag_din
    );

    modport slave (
        output miss_valid, miss_addr, inv_all,
        output mem_arready, mem_rvalid, mem_rdata, mem_rlast,
        input  miss_ready, busy, refill_done, fwd_valid, fwd_data,
        input  mem_arvalid, mem_araddr, mem_arlen, mem_rready, rlast_err,
        input  data_we, data_addr, data_din,
        input  tag_we, tag_addr, tag_valid, tag_din
    );
endinterface

// File: rtl/execute_mem_dcache_refill.sv
// Data cache miss handler: invalidates the target line, fetches the 32-byte
// line as one 8-beat burst, writes every beat into the data RAM, forwards the
// requested word, then publishes the tag as valid. Also runs a full-cache
// invalidate sweep, deferring it behind any refill that is in flight.
module execute_mem_dcache_refill (
    input  logic                               clk,
    input  logic                               resetn,
    execute_mem_dcache_refill_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INVAL = 3'd1,
        REQ   = 3'd2,
        FILL  = 3'd3,
        TAG   = 3'd4,
        SWEEP = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        inv_pend_q, inv_pend_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sc_q, sc_d;
    logic [31:0] addr_q, addr_d;

    logic [18:0] line_tag;
    logic [7:0]  line_idx;
    logic [2:0]  line_word;
    logic        beat;
    logic        unused_byte_offset;

    // Address fields of the line being refilled; the byte offset inside a
    // word is irrelevant to a word-granular refill.
    assign line_tag           = addr_q[31:13];
    assign line_idx           = addr_q[12:5];
    assign line_word          = addr_q[4:2];
    assign unused_byte_offset = ^addr_q[1:0];

    // A beat is transferred whenever memory offers data while we are filling.
    assign beat = (state_q == FILL) && bus.mem_rvalid;

    // State, counters and the latched miss address; reset abandons any
    // refill or sweep in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            inv_pend_q <= 1'b0;
            cnt_q      <= 3'd0;
            sc_q       <= 8'd0;
            addr_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            inv_pend_q <= inv_pend_d;
            cnt_q      <= cnt_d;
            sc_q       <= sc_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state logic and all outputs, decoded from the current state and
    // the live handshake inputs.
    always_comb begin
        state_d         = state_q;
        inv_pend_d      = inv_pend_q;
        cnt_d           = cnt_q;
        sc_d            = sc_q;
        addr_d          = addr_q;

        bus.miss_ready  = (state_q == IDLE) && !inv_pend_q && !bus.inv_all;
        bus.busy        = (state_q != IDLE) || inv_pend_q;
        bus.refill_done = 1'b0;
        bus.fwd_valid   = 1'b0;
        bus.fwd_data    = 32'd0;
        bus.mem_arvalid = 1'b0;
        bus.mem_araddr  = 32'd0;
        bus.mem_arlen   = 8'd7;
        bus.mem_rready  = 1'b0;
        bus.rlast_err   = 1'b0;
        bus.data_we     = 1'b0;
        bus.data_addr   = 11'd0;
        bus.data_din    = 32'd0;
        bus.tag_we      = 1'b0;
        bus.tag_addr    = 8'd0;
        bus.tag_valid   = 1'b0;
        bus.tag_din     = 19'd0;

        // An invalidate that arrives while busy is remembered; repeated
        // pulses simply keep the single pending flag set.
        if (bus.inv_all && (state_q != IDLE)) begin
            inv_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Invalidation has priority over a simultaneous miss.
                if (bus.inv_all || inv_pend_q) begin
                    state_d = SWEEP;
                    sc_d    = 8'd0;
                end else if (bus.miss_valid) begin
                    addr_d  = bus.miss_addr;
                    state_d = INVAL;
                end
            end

            INVAL: begin
                // Kill the old line first so a half-written line never hits.
                bus.tag_we    = 1'b1;
                bus.tag_addr  = line_idx;
                bus.tag_valid = 1'b0;
                bus.tag_din   = line_tag;
                state_d       = REQ;
            end

            REQ: begin
                bus.mem_arvalid = 1'b1;
                bus.mem_araddr  = {addr_q[31:5], 5'b0};
                if (bus.mem_arready) begin
                    cnt_d   = 3'd0;
                    state_d = FILL;
                end
            end

            FILL: begin
                bus.mem_rready = 1'b1;
                bus.data_addr  = {line_idx, cnt_q};
                bus.data_din   = bus.mem_rdata;
                if (beat) begin
                    bus.data_we = 1'b1;
                    cnt_d       = cnt_q + 3'd1;
                    if (cnt_q == line_word) begin
                        bus.fwd_valid = 1'b1;
                        bus.fwd_data  = bus.mem_rdata;
                    end
                    // Our own beat count decides where the burst ends; a
                    // misplaced rlast is only reported.
                    bus.rlast_err = bus.mem_rlast ^ (cnt_q == 3'd7);
                    if (cnt_q == 3'd7) begin
                        state_d = TAG;
                    end
                end
            end

            TAG: begin
                bus.tag_we      = 1'b1;
                bus.tag_addr    = line_idx;
                bus.tag_valid   = 1'b1;
                bus.tag_din     = line_tag;
                bus.refill_done = 1'b1;
                if (inv_pend_q) begin
                    state_d = SWEEP;
                    sc_d    = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end

            SWEEP: begin
                bus.tag_we    = 1'b1;
                bus.tag_addr  = sc_q;
                bus.tag_valid = 1'b0;
                bus.tag_din   = 19'd0;
                sc_d          = sc_q + 8'd1;
                if (sc_q == 8'd255) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Starting a sweep satisfies every invalidate requested so far.
        if ((state_d == SWEEP) && (state_q != SWEEP)) begin
            inv_pend_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_mem_dcache_refill.sv
// Self-checking bench for the dcache refill controller: a table of miss
// transactions driven against a small memory responder, a scoreboard of
// expected tag/data/forward writes, and hand-written sweep and reset cases.
module tb_execute_mem_dcache_refill;

    logic clk;
    logic resetn;

    execute_mem_dcache_refill_if bus();

    execute_mem_dcache_refill dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stall;
        int          errBeat;
        int          invBeat;
        logic [7:0]  expIdx;
        logic [18:0] expTag;
        logic [2:0]  expWord;
        logic [31:0] expAraddr;
        int          expErrs;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic        valid;
        logic [18:0] din;
    } tagExp_t;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] din;
    } dataExp_t;

    tagExp_t     expTag[$];
    dataExp_t    expData[$];
    logic [31:0] expFwd[$];

    vec_t vecs[5];

    int numChecks     = 0;
    int numErrors     = 0;
    int cycleCount    = 0;
    int rlastErrCount = 0;
    int sweepWrites;
    bit sweepReady;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure refill latency
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case a handshake never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required run completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        numChecks++;
        if (act !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycleCount);
        end
    endtask

    function automatic logic [31:0] beatData(input logic [31:0] a, input int k);
        return (a ^ 32'hA5A5_0F0F) + 32'(k) * 32'h0101_1001;
    endfunction

    // Scoreboard: every observed write or forward must match the oldest
    // expectation queued by the stimulus.
    always @(negedge clk) begin : scoreboard
        tagExp_t     te;
        dataExp_t    de;
        logic [31:0] fe;
        if (bus.tag_we) begin
            checkOutput("tag_write_queued", 64'(expTag.size() != 0), 64'd1);
            if (expTag.size() != 0) begin
                te = expTag.pop_front();
                checkOutput("tag_addr", 64'(bus.tag_addr), 64'(te.addr));
                checkOutput("tag_valid", 64'(bus.tag_valid), 64'(te.valid));
                checkOutput("tag_din", 64'(bus.tag_din), 64'(te.din));
            end
        end
        if (bus.data_we) begin
            checkOutput("data_write_queued", 64'(expData.size() != 0), 64'd1);
            if (expData.size() != 0) begin
                de = expData.pop_front();
                checkOutput("data_addr", 64'(bus.data_addr), 64'(de.addr));
                checkOutput("data_din", 64'(bus.data_din), 64'(de.din));
            end
        end
        if (bus.fwd_valid) begin
            checkOutput("fwd_queued", 64'(expFwd.size() != 0), 64'd1);
            if (expFwd.size() != 0) begin
                fe = expFwd.pop_front();
                checkOutput("fwd_data", 64'(bus.fwd_data), 64'(fe));
            end
        end
        if (bus.rlast_err) rlastErrCount++;
    end

    // One complete miss: queue expectations, present the miss, answer the
    // burst request, stream the beats and wait for the tag publish.
    task automatic applyStimulus(input vec_t v);
        int      acceptCycle;
        int      doneCycle;
        int      errBase;
        int      k;
        int      pulses;
        bit      arDone;
        bit      doneSeen;
        bit      sweepIdle;
        tagExp_t te;
        dataExp_t de;

        te = '{v.expIdx, 1'b0, v.expTag};
        expTag.push_back(te);
        for (int b = 0; b < 8; b++) begin
            de = '{{v.expIdx, 3'(b)}, beatData(v.addr, b)};
            expData.push_back(de);
        end
        te = '{v.expIdx, 1'b1, v.expTag};
        expTag.push_back(te);
        if (v.invBeat >= 0) begin
            for (int i = 0; i < 256; i++) begin
                te = '{8'(i), 1'b0, 19'd0};
                expTag.push_back(te);
            end
        end
        expFwd.push_back(beatData(v.addr, int'(v.expWord)));
        errBase     = rlastErrCount;
        acceptCycle = 0;
        doneCycle   = 0;

        #1;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = v.addr;
        @(negedge clk);
        checkOutput("miss_ready_idle", 64'(bus.miss_ready), 64'd1);
        acceptCycle = cycleCount;
        @(posedge clk);

        arDone = 1'b0;
        for (int c = 0; c < 64 && !arDone; c++) begin
            #1;
            bus.miss_valid  = 1'b0;
            bus.mem_arready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            checkOutput("miss_ready_req", 64'(bus.miss_ready), 64'd0);
            checkOutput("arvalid_timing", 64'(bus.mem_arvalid), 64'((c == 0) ? 0 : 1));
            if (bus.mem_arvalid) begin
                checkOutput("araddr", 64'(bus.mem_araddr), 64'(v.expAraddr));
                checkOutput("arlen", 64'(bus.mem_arlen), 64'd7);
            end
            arDone = bus.mem_arvalid && bus.mem_arready;
            @(posedge clk);
        end
        checkOutput("ar_handshake", 64'(arDone), 64'd1);

        k      = 0;
        pulses = 0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            #1;
            bus.mem_arready = 1'b0;
            bus.mem_rvalid  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_rdata   = bus.mem_rvalid ? beatData(v.addr, k) : (32'hDEAD_0000 + 32'(c));
            bus.mem_rlast   = bus.mem_rvalid && ((k == 7) || (k == v.errBeat));
            bus.inv_all     = 1'b0;
            if (v.invBeat >= 0 && pulses == 0 && k == v.invBeat) begin
                bus.inv_all = 1'b1;
                pulses      = 1;
            end else if (v.invBeat >= 0 && pulses == 1 && k >= v.invBeat + 2) begin
                bus.inv_all = 1'b1;
                pulses      = 2;
            end
            @(negedge clk);
            checkOutput("rready_fill", 64'(bus.mem_rready), 64'd1);
            checkOutput("miss_ready_fill", 64'(bus.miss_ready), 64'd0);
            if (bus.mem_rvalid) k++;
            @(posedge clk);
        end
        checkOutput("beats_taken", 64'(k), 64'd8);

        doneSeen = 1'b0;
        for (int c = 0; c < 4 && !doneSeen; c++) begin
            #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rlast  = 1'b0;
            bus.inv_all    = 1'b0;
            @(negedge clk);
            if (bus.refill_done) begin
                doneSeen  = 1'b1;
                doneCycle = cycleCount;
            end
            @(posedge clk);
        end
        checkOutput("refill_done_seen", 64'(doneSeen), 64'd1);
        if (!v.stall) begin
            checkOutput("refill_latency", 64'(doneCycle - acceptCycle), 64'd11);
        end
        checkOutput("data_writes_left", 64'(expData.size()), 64'd0);
        checkOutput("fwd_left", 64'(expFwd.size()), 64'd0);
        checkOutput("tag_writes_left", 64'(expTag.size()), 64'((v.invBeat >= 0) ? 256 : 0));
        checkOutput("rlast_err_count", 64'(rlastErrCount - errBase), 64'(v.expErrs));

        if (v.invBeat >= 0) begin
            @(negedge clk);
            checkOutput("sweep_follows_tag", 64'(bus.tag_we), 64'd1);
            checkOutput("sweep_first_idx", 64'(bus.tag_addr), 64'd0);
            sweepIdle = 1'b0;
            for (int c = 0; c < 300 && !sweepIdle; c++) begin
                @(negedge clk);
                sweepIdle = !bus.busy;
            end
            checkOutput("sweep_ends", 64'(sweepIdle), 64'd1);
            checkOutput("single_sweep", 64'(expTag.size()), 64'd0);
            @(posedge clk);
            repeat (8) @(posedge clk);
            @(negedge clk);
            checkOutput("idle_after_sweep", 64'(bus.miss_ready), 64'd1);
            @(posedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{32'h1234_5678, 1'b0, -1, -1, 8'hB3, 19'h091A2, 3'd6, 32'h1234_5660, 0};
        vecs[1] = '{32'h0000_0000, 1'b1, -1, -1, 8'h00, 19'h00000, 3'd0, 32'h0000_0000, 0};
        vecs[2] = '{32'hFFFF_FFFC, 1'b1, -1, -1, 8'hFF, 19'h7FFFF, 3'd7, 32'hFFFF_FFE0, 0};
        vecs[3] = '{32'hDEAD_BEEF, 1'b0,  3, -1, 8'hF7, 19'h6F56D, 3'd3, 32'hDEAD_BEE0, 1};
        vecs[4] = '{32'h8000_0024, 1'b1, -1,  3, 8'h01, 19'h40000, 3'd1, 32'h8000_0020, 0};

        resetn          = 1'b1;
        bus.miss_valid  = 1'b0;
        bus.miss_addr   = 32'd0;
        bus.inv_all     = 1'b0;
        bus.mem_arready = 1'b1;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = 32'hFFFF_FFFF;
        bus.mem_rlast   = 1'b1;
        #1 resetn = 1'b0;

        // Reset state: everything quiet except arlen and miss_ready
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_arlen", 64'(bus.mem_arlen), 64'd7);
        checkOutput("rst_arvalid", 64'(bus.mem_arvalid), 64'd0);
        checkOutput("rst_araddr", 64'(bus.mem_araddr), 64'd0);
        checkOutput("rst_rready", 64'(bus.mem_rready), 64'd0);
        checkOutput("rst_data_we", 64'(bus.data_we), 64'd0);
        checkOutput("rst_data_din", 64'(bus.data_din), 64'd0);
        checkOutput("rst_tag_we", 64'(bus.tag_we), 64'd0);
        checkOutput("rst_refill_done", 64'(bus.refill_done), 64'd0);
        checkOutput("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        checkOutput("rst_rlast_err", 64'(bus.rlast_err), 64'd0);
        bus.mem_arready = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'd0;
        bus.mem_rlast   = 1'b0;
        #2 resetn = 1'b1;
        @(posedge clk);

        // Table of refills
        for (int i = 0; i < 5; i++) begin
            $display("[TB] refill vector %0d addr 0x%08h", i, vecs[i].addr);
            applyStimulus(vecs[i]);
        end

        // Sweep from IDLE racing a miss: the invalidate wins
        $display("[TB] sweep from idle");
        #1;
        bus.inv_all    = 1'b1;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_1040;
        for (int i = 0; i < 256; i++) begin
            expTag.push_back('{8'(i), 1'b0, 19'd0});
        end
        @(negedge clk);
        checkOutput("inv_beats_miss", 64'(bus.miss_ready), 64'd0);
        @(posedge clk);
        sweepReady  = 1'b0;
        sweepWrites = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            bus.inv_all    = 1'b0;
            bus.miss_valid = 1'b1;
            @(negedge clk);
            if (bus.miss_ready) sweepReady = 1'b1;
            if (bus.tag_we) sweepWrites++;
            @(posedge clk);
        end
        checkOutput("sweep_miss_ready_low", 64'(sweepReady), 64'd0);
        checkOutput("sweep_write_count", 64'(sweepWrites), 64'd256);
        #1 bus.miss_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_sweep", 64'(bus.miss_ready), 64'd1);
        checkOutput("busy_after_sweep", 64'(bus.busy), 64'd0);
        checkOutput("sweep_tag_left", 64'(expTag.size()), 64'd0);
        @(posedge clk);

        // Reset asserted during beat 4 of a refill
        $display("[TB] reset during refill");
        #1;
        bus.miss_valid  = 1'b1;
        bus.miss_addr   = 32'h1234_5678;
        bus.mem_arready = 1'b1;
        expTag.push_back('{8'hB3, 1'b0, 19'h091A2});
        for (int b = 0; b < 4; b++) begin
            expData.push_back('{{8'hB3, 3'(b)}, beatData(32'h1234_5678, b)});
        end
        @(posedge clk);
        #1 bus.miss_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            #1;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beatData(32'h1234_5678, b);
            bus.mem_rlast  = 1'b0;
            @(posedge clk);
        end
        #1 bus.mem_rdata = beatData(32'h1234_5678, 4);
        #1 resetn = 1'b0;
        #1;
        checkOutput("mid_rst_data_we", 64'(bus.data_we), 64'd0);
        checkOutput("mid_rst_data_din", 64'(bus.data_din), 64'd0);
        checkOutput("mid_rst_rready", 64'(bus.mem_rready), 64'd0);
        checkOutput("mid_rst_tag_we", 64'(bus.tag_we), 64'd0);
        checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("mid_rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        checkOutput("beats_before_rst", 64'(expData.size()), 64'd0);
        @(posedge clk);
        #2;
        resetn          = 1'b1;
        bus.mem_rvalid  = 1'b0;
        bus.mem_arready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        checkOutput("post_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("post_rst_no_tag", 64'(expTag.size()), 64'd0);
        @(posedge clk);
        applyStimulus(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
        $finish;
    end

endmodule
